fetch_decode_ctrl: RTL and testbench

Instruction sequencer that sits directly upstream of the 16×12 program ROM and directly upstream of the accumulator/register datapath. It holds the program counter and drives the ROM address. It latches the returned 12-bit instruction word into an instruction register and decodes it into one-cycle datapath control strobes. It runs a two-phase FETCH/EXEC state machine and also handles program restart (`rst` opcode) and halt.

---
 rtl/fetch_decode_ctrl_if.sv | 38 +++
 rtl/fetch_decode_ctrl.sv | 114 +++++++++++
 tb/tb_fetch_decode_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_ctrl_if.sv
// Sequencer-side bundle: run enable, ROM address/data and datapath control.
//   EN        run enable (driven by the environment)
//   ROM_ADDR  ROM address = PC
//   ROM_DATA  instruction word, combinational from ROM_ADDR
//   ACC_ADD/ACC_INC/ACC_LDR/ACC_LDI/R_WE  one-cycle datapath strobes
//   IMM       IR[7:4]
//   EXEC      FSM is in EXEC
//   HALTED    FSM is in HALT
interface fetch_decode_ctrl_if #(
    parameter int unsigned WIDTH      = 12,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  EN;
    logic [ADDR_WIDTH-1:0] ROM_ADDR;
    logic [WIDTH-1:0]      ROM_DATA;
    logic                  ACC_ADD;
    logic                  ACC_INC;
    logic                  ACC_LDR;
    logic                  ACC_LDI;
    logic                  R_WE;
    logic [3:0]            IMM;
    logic                  EXEC;
    logic                  HALTED;

    // Sequencer side
    modport master (
        input  EN, ROM_DATA,
        output ROM_ADDR, ACC_ADD, ACC_INC, ACC_LDR, ACC_LDI, R_WE,
               IMM, EXEC, HALTED
    );

    // ROM/datapath/environment side
    modport slave (
        output EN, ROM_DATA,
        input  ROM_ADDR, ACC_ADD, ACC_INC, ACC_LDR, ACC_LDI, R_WE,
               IMM, EXEC, HALTED
    );
endinterface

// File: rtl/fetch_decode_ctrl.sv
// Two-phase FETCH/EXEC instruction sequencer with restart and halt.
// Holds PC (drives the ROM address), latches the ROM word into IR and
// decodes IR[11:8] into one-cycle datapath strobes during EXEC.
//   CLK  clock, rising edge
//   RST  synchronous active-high reset
//   bus  fetch_decode_ctrl_if.master (EN, ROM_ADDR, ROM_DATA, strobes,
//        IMM, EXEC, HALTED)
module fetch_decode_ctrl #(
    parameter int unsigned WIDTH      = 12,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                CLK,
    input  logic                RST,
    fetch_decode_ctrl_if.master bus
);
    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'h5;
    localparam logic [OP_W-1:0] OP_INC  = 4'h9;
    localparam logic [OP_W-1:0] OP_LDR  = 4'hA;
    localparam logic [OP_W-1:0] OP_STR  = 4'hB;
    localparam logic [OP_W-1:0] OP_NOP  = 4'hC;
    localparam logic [OP_W-1:0] OP_LDI  = 4'hD;
    localparam logic [OP_W-1:0] OP_RST  = 4'hE;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    localparam logic [WIDTH-1:0] IR_NOP = {OP_NOP, (WIDTH-OP_W)'(0)};

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [WIDTH-1:0]      ir;
    logic [OP_W-1:0]       op;

    logic add_s;
    logic inc_s;
    logic ldr_s;
    logic ldi_s;
    logic we_s;
    logic strobe_ok;

    assign op = ir[WIDTH-1 -: OP_W];

    // Sequencer state, PC and IR; EN low freezes everything
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_FETCH;
            pc    <= '0;
            ir    <= IR_NOP;
        end else if (bus.EN) begin
            case (state)
                S_FETCH: begin
                    ir    <= bus.ROM_DATA;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (op == OP_HALT) begin
                        state <= S_HALT;
                    end else begin
                        state <= S_FETCH;
                        pc    <= (op == OP_RST) ? '0 : pc + ADDR_WIDTH'(1);
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // Strobes depend only on IR and state, so ROM address changes never glitch
    // them; reset also masks them so an interrupted EXEC has no effect.
    assign strobe_ok = bus.EN && !RST && (state == S_EXEC);

    always_comb begin
        add_s = 1'b0;
        inc_s = 1'b0;
        ldr_s = 1'b0;
        ldi_s = 1'b0;
        we_s  = 1'b0;
        if (strobe_ok) begin
            case (op)
                OP_ADD:  add_s = 1'b1;
                OP_INC:  inc_s = 1'b1;
                OP_LDR:  ldr_s = 1'b1;
                OP_STR:  we_s  = 1'b1;
                OP_LDI:  ldi_s = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.ROM_ADDR = pc;
    assign bus.ACC_ADD  = add_s;
    assign bus.ACC_INC  = inc_s;
    assign bus.ACC_LDR  = ldr_s;
    assign bus.ACC_LDI  = ldi_s;
    assign bus.R_WE     = we_s;
    assign bus.IMM      = ir[WIDTH-OP_W-1 -: 4];
    assign bus.EXEC     = (state == S_EXEC);
    assign bus.HALTED   = (state == S_HALT);

    // Low IR bits are reserved and deliberately ignored
    logic unused_rsvd;
    assign unused_rsvd = ^ir[WIDTH-OP_W-5:0];
endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Self-checking bench for fetch_decode_ctrl: instruction-level reference
// interpreter plus a reference datapath driven by the DUT strobes.
module tb_fetch_decode_ctrl;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    fetch_decode_ctrl_if #(.WIDTH(12), .ADDR_WIDTH(4)) bus ();
    fetch_decode_ctrl #(.WIDTH(12), .ADDR_WIDTH(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    logic [11:0] rom [16];
    assign bus.ROM_DATA = rom[bus.ROM_ADDR];

    // Reference datapath reacting to the DUT strobes
    logic [7:0] dp_a, dp_r;
    always @(posedge CLK) begin
        if (RST) begin
            dp_a <= 8'd0;
            dp_r <= 8'd0;
        end else begin
            if (bus.ACC_ADD) dp_a <= dp_a + dp_r;
            if (bus.ACC_INC) dp_a <= dp_a + 8'd1;
            if (bus.ACC_LDR) dp_a <= dp_r;
            if (bus.ACC_LDI) dp_a <= {4'd0, bus.IMM};
            if (bus.R_WE)    dp_r <= dp_a;
        end
    end

    int checks = 0;
    int errors = 0;

    // Instruction-level model
    logic [3:0] m_pc;
    bit         m_halt;
    logic [7:0] m_a, m_r;

    // {add, inc, ldr, ldi, we} expected in EXEC for an opcode
    function automatic logic [4:0] exp_strobes(input logic [3:0] op);
        case (op)
            4'h5:    return 5'b10000;
            4'h9:    return 5'b01000;
            4'hA:    return 5'b00100;
            4'hD:    return 5'b00010;
            4'hB:    return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic logic [4:0] got_strobes();
        return {bus.ACC_ADD, bus.ACC_INC, bus.ACC_LDR, bus.ACC_LDI, bus.R_WE};
    endfunction

    task automatic load_std();
        logic [11:0] p [16] = '{12'hC00, 12'hD20, 12'h900, 12'h900,
                                12'hB00, 12'hD30, 12'hB00, 12'hA00,
                                12'h500, 12'h900, 12'h900, 12'hC00,
                                12'h300, 12'hC00, 12'hE00, 12'hC00};
        for (int i = 0; i < 16; i++) rom[i] = p[i];
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.EN = 1'($urandom_range(0, 1));
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (bus.ROM_ADDR !== 4'd0) begin errors++; $display("FAIL reset_addr got=%0h exp=0", bus.ROM_ADDR); end
        checks++;
        if (got_strobes() !== 5'b0) begin errors++; $display("FAIL reset_strobes got=%b exp=00000", got_strobes()); end
        checks++;
        if ({bus.EXEC, bus.HALTED} !== 2'b00) begin errors++; $display("FAIL reset_state got=%b exp=00", {bus.EXEC, bus.HALTED}); end
        checks++;
        if (bus.IMM !== 4'd0) begin errors++; $display("FAIL reset_imm got=%0h exp=0", bus.IMM); end
        RST = 1'b0;
        m_pc = 4'd0; m_halt = 1'b0; m_a = 8'd0; m_r = 8'd0;
    endtask

    // One instruction with optional EN-low gaps before FETCH and before EXEC
    task automatic do_instr(input int gap_f, input int gap_e);
        logic [11:0] w;
        logic [3:0]  op, imm;
        w = rom[m_pc];
        op = w[11:8];
        imm = w[7:4];
        repeat (gap_f) begin
            bus.EN = 1'b0; #1;
            checks++;
            if (got_strobes() !== 5'b0 || bus.ROM_ADDR !== m_pc || bus.EXEC !== 1'b0) begin
                errors++; $display("FAIL gap_fetch strobes=%b addr=%0h exec=%b exp addr=%0h", got_strobes(), bus.ROM_ADDR, bus.EXEC, m_pc);
            end
            @(posedge CLK); #1;
        end
        bus.EN = 1'b1; #1;
        checks++;
        if (bus.ROM_ADDR !== m_pc || bus.EXEC !== 1'b0 || bus.HALTED !== 1'b0 || got_strobes() !== 5'b0) begin
            errors++; $display("FAIL fetch addr=%0h exec=%b halted=%b strobes=%b exp addr=%0h", bus.ROM_ADDR, bus.EXEC, bus.HALTED, got_strobes(), m_pc);
        end
        @(posedge CLK); #1;
        repeat (gap_e) begin
            bus.EN = 1'b0; #1;
            checks++;
            if (got_strobes() !== 5'b0 || bus.EXEC !== 1'b1 || bus.IMM !== imm) begin
                errors++; $display("FAIL gap_exec strobes=%b exec=%b imm=%0h exp imm=%0h", got_strobes(), bus.EXEC, bus.IMM, imm);
            end
            @(posedge CLK); #1;
        end
        bus.EN = 1'b1; #1;
        checks++;
        if (bus.EXEC !== 1'b1 || got_strobes() !== exp_strobes(op) || bus.IMM !== imm || bus.ROM_ADDR !== m_pc) begin
            errors++; $display("FAIL exec pc=%0h op=%0h exec=%b strobes=%b exp=%b imm=%0h exp=%0h", m_pc, op, bus.EXEC, got_strobes(), exp_strobes(op), bus.IMM, imm);
        end
        case (op)
            4'h5: m_a = m_a + m_r;
            4'h9: m_a = m_a + 8'd1;
            4'hA: m_a = m_r;
            4'hB: m_r = m_a;
            4'hD: m_a = {4'd0, imm};
            default: ;
        endcase
        if (op == 4'hF) m_halt = 1'b1;
        else if (op == 4'hE) m_pc = 4'd0;
        else m_pc = 4'((int'(m_pc) + 1) % 16);
        @(posedge CLK); #1;
    endtask

    task automatic check_dp(input string tag);
        checks++;
        if (dp_a !== m_a || dp_r !== m_r) begin
            errors++; $display("FAIL %s A=%0d R=%0d exp A=%0d R=%0d", tag, dp_a, dp_r, m_a, m_r);
        end
    endtask

    task automatic test_standard_program();
        load_std();
        test_reset();
        for (int i = 0; i < 14; i++) do_instr(0, 0);
        checks++;
        if (dp_a !== 8'd8 || dp_r !== 8'd3) begin
            errors++; $display("FAIL std_at_E A=%0d R=%0d exp A=8 R=3", dp_a, dp_r);
        end
        do_instr(0, 0);
        checks++;
        if (bus.ROM_ADDR !== 4'd0) begin errors++; $display("FAIL std_restart addr=%0h exp=0", bus.ROM_ADDR); end
        for (int i = 0; i < 6; i++) do_instr(0, 0);
        check_dp("std_repeat");
    endtask

    task automatic test_en_gaps();
        load_std();
        test_reset();
        for (int i = 0; i < 14; i++) begin
            do_instr((i == 2) ? 3 : 0, (i == 4) ? 3 : 0);
        end
        checks++;
        if (dp_a !== 8'd8 || dp_r !== 8'd3) begin
            errors++; $display("FAIL gaps_at_E A=%0d R=%0d exp A=8 R=3", dp_a, dp_r);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) rom[i] = 12'hC00;
        test_reset();
        for (int i = 0; i < 16; i++) do_instr(0, 0);
        checks++;
        if (bus.ROM_ADDR !== 4'd0) begin errors++; $display("FAIL wrap addr=%0h exp=0", bus.ROM_ADDR); end
        do_instr(0, 0);
        check_dp("wrap_dp");
    endtask

    task automatic test_halt();
        load_std();
        rom[3] = 12'hF00;
        test_reset();
        for (int i = 0; i < 4; i++) do_instr(0, 0);
        for (int c = 0; c < 22; c++) begin
            bus.EN = 1'($urandom_range(0, 1)); #1;
            checks++;
            if (bus.HALTED !== 1'b1 || bus.ROM_ADDR !== 4'd3 || bus.EXEC !== 1'b0 || got_strobes() !== 5'b0) begin
                errors++; $display("FAIL halt_hold halted=%b addr=%0h exec=%b strobes=%b exp 1/3/0/00000", bus.HALTED, bus.ROM_ADDR, bus.EXEC, got_strobes());
            end
            @(posedge CLK); #1;
        end
        check_dp("halt_dp");
        test_reset();
        do_instr(0, 0);
    endtask

    task automatic test_rst_mid_exec();
        load_std();
        rom[3] = 12'h300;
        rom[5] = 12'h900;
        test_reset();
        for (int i = 0; i < 5; i++) do_instr(0, 0);
        check_dp("op3_nop_dp");
        bus.EN = 1'b1; #1;
        @(posedge CLK); #1;
        RST = 1'b1; #1;
        checks++;
        if (got_strobes() !== 5'b0) begin errors++; $display("FAIL rst_exec_strobes got=%b exp=00000", got_strobes()); end
        @(posedge CLK); #1;
        RST = 1'b0; #1;
        checks++;
        if (bus.ROM_ADDR !== 4'd0 || bus.EXEC !== 1'b0 || bus.IMM !== 4'd0 || bus.HALTED !== 1'b0) begin
            errors++; $display("FAIL rst_exec_after addr=%0h exec=%b imm=%0h halted=%b exp 0/0/0/0", bus.ROM_ADDR, bus.EXEC, bus.IMM, bus.HALTED);
        end
        m_pc = 4'd0; m_halt = 1'b0; m_a = 8'd0; m_r = 8'd0;
        for (int i = 0; i < 3; i++) do_instr(0, 0);
    endtask

    task automatic test_random();
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < 16; i++) rom[i] = 12'($urandom);
            test_reset();
            for (int n = 0; n < 40 && !m_halt; n++) begin
                do_instr($urandom_range(0, 2), $urandom_range(0, 2));
            end
            if (m_halt) begin
                repeat (3) begin
                    bus.EN = 1'b1; #1;
                    checks++;
                    if (bus.HALTED !== 1'b1 || bus.ROM_ADDR !== m_pc || got_strobes() !== 5'b0) begin
                        errors++; $display("FAIL rand_halt halted=%b addr=%0h strobes=%b exp addr=%0h", bus.HALTED, bus.ROM_ADDR, got_strobes(), m_pc);
                    end
                    @(posedge CLK); #1;
                end
            end
            check_dp("rand_dp");
        end
    endtask

    initial begin
        RST = 1'b1;
        bus.EN = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 12'hC00;
        @(posedge CLK); #1;
        test_reset();
        test_standard_program();
        test_en_gaps();
        test_wrap();
        test_halt();
        test_rst_mid_exec();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
